// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: core-side command handshake for the PS/2 host transmitter.
// The master (core) supplies a byte and a one-cycle start; the slave (transmitter)
// reports busy and one-cycle done/err completion pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the bus, issues the
// request-to-send, shifts data/parity/stop on device clocks and checks the ACK.
// Optional macro PS2_TX_RETRY_EN: on failure, re-run the whole request up to
// MAX_RETRY more times before reporting err. Without it, one attempt only.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 480,
  parameter int unsigned REQ_CYC     = 8,
  parameter int unsigned START_TOUT  = 65535,
  parameter int unsigned EDGE_TOUT   = 4095,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kclk_i,
  input  logic         kdat_i,
  output logic         kclk_oe_o,
  output logic         kdat_oe_o,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned MaxTout = (START_TOUT > EDGE_TOUT) ? START_TOUT : EDGE_TOUT;
  localparam int unsigned MaxCnt  = (MaxTout > INHIBIT_CYC) ? MaxTout : INHIBIT_CYC;
  localparam int unsigned CntW    = $clog2(MaxCnt + 1);
  localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RetryLim = MAX_RETRY;
`else
  // A limit of zero makes can_retry constant-false, leaving a single attempt.
  localparam int unsigned RetryLim = 0;
`endif

  typedef enum logic [3:0] {
    StIdle, StInhibit, StReq, StWaitFirst, StShift, StAck, StWaitIdle, StDone, StFail
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [8:0]        shreg_q, shreg_d;     // {parity, data}, LSB shifted out first
  logic [RetryW-1:0] retry_q, retry_d;
  logic [1:0]        kclk_sync_q, kdat_sync_q;
  logic              kclk_prev_q;
  logic              kclk_oe_q, kclk_oe_d, kdat_oe_q, kdat_oe_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              kclk_s, kdat_s, fall, fail, can_retry, dat_nxt;

  assign kclk_s    = kclk_sync_q[1];
  assign kdat_s    = kdat_sync_q[1];
  assign fall      = kclk_prev_q & ~kclk_s;
  assign can_retry = (retry_q != RetryW'(RetryLim));

  // Two-flop synchronisers plus a delayed copy of kclk for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_q <= 2'b11;
      kdat_sync_q <= 2'b11;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[0], kclk_i};
      kdat_sync_q <= {kdat_sync_q[0], kdat_i};
      kclk_prev_q <= kclk_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      retry_q   <= '0;
      kclk_oe_q <= 1'b0;
      kdat_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      retry_q   <= retry_d;
      kclk_oe_q <= kclk_oe_d;
      kdat_oe_q <= kdat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state: sequencing, bit shifting and timeout supervision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    retry_d   = retry_q;
    dat_nxt   = kdat_oe_q;
    fail      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.tx_start) begin
          shreg_d = {~^bus.tx_data, bus.tx_data};
          state_d = StInhibit;
        end
      end
      StInhibit: if (cnt_q == CntW'(INHIBIT_CYC - 1)) state_d = StReq;
      StReq: begin
        if (cnt_q == CntW'(REQ_CYC - 1)) begin
          bit_idx_d = '0;
          state_d   = StWaitFirst;
        end
      end
      StWaitFirst: begin
        if (fall) begin
          dat_nxt   = ~shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = 4'd1;
          state_d   = StShift;
        end else if (cnt_q == CntW'(START_TOUT)) begin
          fail = 1'b1;
        end
      end
      StShift: begin
        if (fall) begin
          if (bit_idx_q == 4'd9) begin
            dat_nxt = 1'b0;  // stop bit: release kdat
            state_d = StAck;
          end else begin
            dat_nxt   = ~shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else if (cnt_q == CntW'(EDGE_TOUT)) begin
          fail = 1'b1;
        end
      end
      StAck: begin
        if (fall) begin
          if (kdat_s) fail = 1'b1;
          else        state_d = StWaitIdle;
        end else if (cnt_q == CntW'(EDGE_TOUT)) begin
          fail = 1'b1;
        end
      end
      StWaitIdle: begin
        if (kclk_s && kdat_s)                   state_d = StDone;
        else if (cnt_q == CntW'(EDGE_TOUT)) fail    = 1'b1;
      end
      StDone: state_d = StIdle;
      StFail: begin
        if (can_retry) begin
          retry_d = retry_q + 1'b1;
          state_d = StInhibit;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fail) state_d = StFail;
    if (state_d == StIdle) retry_d = '0;
    // Falls only restart the timer once the device owns kclk.
    if ((state_d != state_q) ||
        (fall && (state_q inside {StWaitFirst, StShift, StAck}))) begin
      cnt_d = '0;
    end
  end

  // Outputs decoded from the next state so they are registered with it.
  always_comb begin
    kclk_oe_d = state_d inside {StInhibit, StReq};
    kdat_oe_d = 1'b0;
    if (state_d == StReq) begin
      kdat_oe_d = 1'b1;
    end else if (state_d inside {StWaitFirst, StShift, StAck}) begin
      kdat_oe_d = dat_nxt;
    end
    done_d = (state_d == StDone);
    err_d  = (state_d == StFail) && !can_retry;
    busy_d = !(state_d inside {StIdle, StDone}) && !err_d;
  end

  assign kclk_oe_o = kclk_oe_q;
  assign kdat_oe_o = kdat_oe_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. LED set 0xED, reset 0xFF) from the core to the keyboard over the shared kclk/kdat open-drain lines.
- Sits beside the PS/2 keyboard receiver in the keyboard subsystem. Its busy output lets the receiver ignore bus activity during a transmission.
- Performs the host request sequence, shifts out data, parity and stop bits on device-generated clocks, then checks the device ACK bit.

Parameters:
- INHIBIT_CYC, 480: clk cycles kclk is held low before the request (120 us at 4 MHz).
- REQ_CYC, 8: clk cycles kdat is held low while kclk is still held low, before kclk is released.
- START_TOUT, 65535: max clk cycles from kclk release to the first device falling edge.
- EDGE_TOUT, 4095: max clk cycles between consecutive device falling edges, or between the ACK edge and bus idle.
- MAX_RETRY, 2: automatic retries after an error (used only with the optional feature).

Ports:
- clk, input, 1: system/CPU clock.
- rst_n, input, 1: asynchronous active-low reset.
- kclk, input, 1: PS/2 clock line as read.
- kdat, input, 1: PS/2 data line as read.
- kclk_oe, output, 1: 1 = pull kclk low; 0 = release.
- kdat_oe, output, 1: 1 = pull kdat low; 0 = release.
- tx_data, input, 8: byte to send.
- tx_start, input, 1: single-cycle start request.
- busy, output, 1: transmission in progress.
- done, output, 1: one-cycle pulse, byte ACKed.
- err, output, 1: one-cycle pulse, transfer failed.

Behaviour:
- Reset (async, rst_n=0): kclk_oe=0, kdat_oe=0, busy=0, done=0, err=0, state=IDLE, all counters cleared. If reset is asserted mid-transfer, both lines are released immediately.
- Input sync: kclk and kdat each pass through 2 flops. fall = synced kclk was 1 on the previous cycle and is 0 now.
- IDLE:
  - tx_start=1 latches tx_data and computes parity = ~^tx_data (odd parity).
  - busy=1 from the next cycle. Go to INHIBIT.
  - tx_start while busy is ignored.
- INHIBIT: kclk_oe=1, kdat_oe=0 for INHIBIT_CYC cycles, then go to REQ.
- REQ: kclk_oe=1, kdat_oe=1 for REQ_CYC cycles. Then kclk_oe=0 (kdat stays low; this is the start bit), bit index=0, go to WAIT_FIRST.
- WAIT_FIRST → SHIFT:
  - Each fall drives the next bit on kdat_oe (kdat_oe = ~bit), within 1 cycle of the detected edge.
  - Falls 1-8: D0..D7, LSB first. Fall 9: parity. Fall 10: stop (kdat_oe=0).
- ACK:
  - Fall 11: sample synced kdat. 0 = ACK OK; 1 = no ACK → FAIL.
  - After ACK OK, wait for synced kclk=1 and kdat=1, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- FAIL: release both lines, err=1 for one cycle, busy=0, return to IDLE.
- Timeouts (counter cleared on every fall and on every state entry):
  - WAIT_FIRST exceeding START_TOUT → FAIL.
  - SHIFT/ACK, or the post-ACK idle wait, exceeding EDGE_TOUT → FAIL.
- done and err never assert in the same cycle.
- Edge cases:
  - A fall during INHIBIT or REQ is ignored, since the host owns kclk.
  - tx_start in the same cycle as DONE/FAIL is ignored; the block accepts a new start only in IDLE.
- Outputs are registered; no combinational path from kclk/kdat to any output.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - On any FAIL condition, both lines are released and the block re-enters INHIBIT with the same latched byte.
  - Up to MAX_RETRY retries; busy stays 1 throughout.
  - err pulses only after the final attempt fails. done pulses on the first successful attempt.
  - Retry count clears on entering IDLE.
- Not defined: a single attempt; FAIL goes straight to err and IDLE. MAX_RETRY is unused.

Test Plan:
- Send 0xED with a device model clocking at a 25 kHz-equivalent rate:
  - kclk_oe high for 480 cycles, then kdat_oe high.
  - Sampled bits on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Model ACK low → done pulse, busy falls.
- Send 0x01, check parity=0. Send 0xFF, check parity=1. Both complete with done.
- Device model never drives ACK low (kdat high at fall 11) → err pulse, done stays 0, kclk_oe=0 and kdat_oe=0.
- Device never starts clocking → err exactly START_TOUT+1 cycles after kclk release. Device stops after 5 edges → err after EDGE_TOUT.
- Assert rst_n low during bit 4 → all outputs 0 within the same cycle (async), state IDLE. A subsequent tx_start of 0x55 completes normally.
- PS2_TX_RETRY_EN with MAX_RETRY=2 and the device NAKing the first two attempts → three INHIBIT phases, no err, a single done. NAKing all attempts → exactly one err after the 3rd attempt.
